// File: rtl/memory_arbiter_if.sv
// Signal bundle for the memory arbiter: fetch stage, memory stage, shared memory port.
// The slave modport is the arbiter's view; master is the pipeline/memory environment.
interface memory_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 20
);
   // fetch stage
   logic              IF_Req_IN;
   logic [ADDR_W-1:0] IF_Addr_IN;
   logic              IF_Grant_OUT;
   logic              IF_Valid_OUT;
   logic [WORD_W-1:0] IF_Data_OUT;
   // memory stage
   logic              MEM_Req_IN;
   logic              MEM_Write_IN;
   logic [ADDR_W-1:0] MEM_Addr_IN;
   logic [WORD_W-1:0] MEM_WData_IN;
   logic              MEM_Grant_OUT;
   logic              MEM_Valid_OUT;
   logic [WORD_W-1:0] MEM_RData_OUT;
   // shared memory port
   logic              Mem_Req_OUT;
   logic              Mem_Write_OUT;
   logic [ADDR_W-1:0] Mem_Addr_OUT;
   logic [WORD_W-1:0] Mem_WData_OUT;
   logic              Mem_Ack_IN;
   logic [WORD_W-1:0] Mem_RData_IN;
   // status
   logic              Error_OUT;

   modport slave (
      input  IF_Req_IN, IF_Addr_IN,
      output IF_Grant_OUT, IF_Valid_OUT, IF_Data_OUT,
      input  MEM_Req_IN, MEM_Write_IN, MEM_Addr_IN, MEM_WData_IN,
      output MEM_Grant_OUT, MEM_Valid_OUT, MEM_RData_OUT,
      output Mem_Req_OUT, Mem_Write_OUT, Mem_Addr_OUT, Mem_WData_OUT,
      input  Mem_Ack_IN, Mem_RData_IN,
      output Error_OUT
   );

   modport master (
      output IF_Req_IN, IF_Addr_IN,
      input  IF_Grant_OUT, IF_Valid_OUT, IF_Data_OUT,
      output MEM_Req_IN, MEM_Write_IN, MEM_Addr_IN, MEM_WData_IN,
      input  MEM_Grant_OUT, MEM_Valid_OUT, MEM_RData_OUT,
      input  Mem_Req_OUT, Mem_Write_OUT, Mem_Addr_OUT, Mem_WData_OUT,
      output Mem_Ack_IN, Mem_RData_IN,
      input  Error_OUT
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) for one shared memory port.
// MEM wins ties unless IF has been passed over STARVE_LIMIT times in a row; an access
// that sees no acknowledge for TIMEOUT busy cycles is closed with zero data and a sticky error.
module memory_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int WORD_W       = 20,
   parameter int STARVE_LIMIT = 3,
   parameter int TIMEOUT      = 15
) (
   input  logic            CLK,
   input  logic            RESET,
   memory_arbiter_if.slave bus
);

   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_e;

   state_e              state_q,     state_d;
   logic [STARVE_W-1:0] starve_q,    starve_d;
   logic [TMO_W-1:0]    tmo_q,       tmo_d;
   logic                if_grant_q,  if_grant_d;
   logic                if_valid_q,  if_valid_d;
   logic                mem_grant_q, mem_grant_d;
   logic                mem_valid_q, mem_valid_d;
   logic                req_q,       req_d;
   logic                write_q,     write_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [WORD_W-1:0]   wdata_q,     wdata_d;
   logic [WORD_W-1:0]   if_data_q,   if_data_d;
   logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                error_q,     error_d;

   // Arbitration, completion/timeout handling and the next value of every registered output.
   always_comb begin
      // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      if_grant_d  = 1'b0;
      if_valid_d  = 1'b0;
      mem_grant_d = 1'b0;
      mem_valid_d = 1'b0;
      req_d       = req_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      error_d     = error_q;

      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (bus.MEM_Req_IN && !(bus.IF_Req_IN && starve_q == STARVE_MAX)) begin
               state_d     = BUSY_MEM;
               mem_grant_d = 1'b1;
               req_d       = 1'b1;
               write_d     = bus.MEM_Write_IN;
               addr_d      = bus.MEM_Addr_IN;
               wdata_d     = bus.MEM_WData_IN;
               starve_d    = bus.IF_Req_IN ? starve_q + STARVE_W'(1) : '0;
            end else if (bus.IF_Req_IN) begin
               state_d    = BUSY_IF;
               if_grant_d = 1'b1;
               req_d      = 1'b1;
               write_d    = 1'b0;
               addr_d     = bus.IF_Addr_IN;
               wdata_d    = '0;
               starve_d   = '0;
            end else begin
               starve_d = '0;
            end
         end

         BUSY_IF, BUSY_MEM: begin
            if (!bus.IF_Req_IN) starve_d = '0;
            if (bus.Mem_Ack_IN || tmo_q == TMO_LAST) begin
               // Normal completion on acknowledge, otherwise the access has timed out.
               state_d = IDLE;
               req_d   = 1'b0;
               tmo_d   = '0;
               if (!bus.Mem_Ack_IN) error_d = 1'b1;
               if (state_q == BUSY_IF) begin
                  if_valid_d = 1'b1;
                  if_data_d  = bus.Mem_Ack_IN ? bus.Mem_RData_IN : '0;
               end else begin
                  mem_valid_d = 1'b1;
                  if (!bus.Mem_Ack_IN)  mem_rdata_d = '0;
                  else if (!write_q)    mem_rdata_d = bus.Mem_RData_IN;
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers; RESET clears all of them at once, abandoning any access.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         if_grant_q  <= 1'b0;
         if_valid_q  <= 1'b0;
         mem_grant_q <= 1'b0;
         mem_valid_q <= 1'b0;
         req_q       <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         error_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         if_grant_q  <= if_grant_d;
         if_valid_q  <= if_valid_d;
         mem_grant_q <= mem_grant_d;
         mem_valid_q <= mem_valid_d;
         req_q       <= req_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         error_q     <= error_d;
      end
   end

   assign bus.IF_Grant_OUT  = if_grant_q;
   assign bus.IF_Valid_OUT  = if_valid_q;
   assign bus.IF_Data_OUT   = if_data_q;
   assign bus.MEM_Grant_OUT = mem_grant_q;
   assign bus.MEM_Valid_OUT = mem_valid_q;
   assign bus.MEM_RData_OUT = mem_rdata_q;
   assign bus.Mem_Req_OUT   = req_q;
   assign bus.Mem_Write_OUT = write_q;
   assign bus.Mem_Addr_OUT  = addr_q;
   assign bus.Mem_WData_OUT = wdata_q;
   assign bus.Error_OUT     = error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a memory responder with programmable acknowledge delay,
// a transaction-level reference model compared every cycle, and literal checks per scenario.
module tb_memory_arbiter;
   localparam int ADDR_W       = 10;
   localparam int WORD_W       = 20;
   localparam int STARVE_LIMIT = 3;
   localparam int TIMEOUT      = 15;

   localparam int W_IF_GRANT  = 0;
   localparam int W_IF_VALID  = 1;
   localparam int W_MEM_GRANT = 2;
   localparam int W_MEM_VALID = 3;

   localparam int OWN_NONE = 0;
   localparam int OWN_IF   = 1;
   localparam int OWN_MEM  = 2;

   logic CLK = 1'b0;
   logic RESET;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   memory_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

   memory_arbiter #(
      .ADDR_W(ADDR_W), .WORD_W(WORD_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory contents seen by the responder.
   function automatic logic [WORD_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      if (a == 10'h004) return 20'hABCDE;
      return {a ^ 10'h3A5, a};
   endfunction

   // Memory responder: acknowledges on the ack_delay-th cycle of a request (-1 = never);
   // with stray set it also drives acknowledges while no request is pending.
   int ack_delay = 0;
   bit stray     = 1'b0;
   int wait_n    = 0;
   always @(negedge CLK) begin
      if (bus.Mem_Req_OUT === 1'b1) begin
         bus.Mem_Ack_IN   = (ack_delay >= 0) && (wait_n == ack_delay);
         bus.Mem_RData_IN = bus.Mem_Ack_IN ? pattern(bus.Mem_Addr_OUT) : '0;
         wait_n++;
      end else begin
         wait_n           = 0;
         bus.Mem_Ack_IN   = stray;
         bus.Mem_RData_IN = stray ? 20'h12345 : '0;
      end
   end

   // Reference model: one owner at a time, tie rule with a pass-over streak, completion
   // on acknowledge or after TIMEOUT busy cycles.
   int                owner, age, streak;
   logic              e_if_grant, e_if_valid, e_mem_grant, e_mem_valid, e_req, e_write, e_error;
   logic [ADDR_W-1:0] e_addr;
   logic [WORD_W-1:0] e_wdata, e_if_data, e_mem_rdata;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         owner <= OWN_NONE; age <= 0; streak <= 0;
         e_if_grant <= 1'b0; e_if_valid <= 1'b0; e_mem_grant <= 1'b0; e_mem_valid <= 1'b0;
         e_req <= 1'b0; e_write <= 1'b0; e_error <= 1'b0;
         e_addr <= '0; e_wdata <= '0; e_if_data <= '0; e_mem_rdata <= '0;
      end else begin
         e_if_grant <= 1'b0; e_if_valid <= 1'b0; e_mem_grant <= 1'b0; e_mem_valid <= 1'b0;
         if (owner == OWN_NONE) begin
            age <= 0;
            if (bus.MEM_Req_IN && !(bus.IF_Req_IN && streak == STARVE_LIMIT)) begin
               owner <= OWN_MEM; e_mem_grant <= 1'b1; e_req <= 1'b1;
               e_write <= bus.MEM_Write_IN; e_addr <= bus.MEM_Addr_IN; e_wdata <= bus.MEM_WData_IN;
               streak <= bus.IF_Req_IN ? streak + 1 : 0;
            end else if (bus.IF_Req_IN) begin
               owner <= OWN_IF; e_if_grant <= 1'b1; e_req <= 1'b1;
               e_write <= 1'b0; e_addr <= bus.IF_Addr_IN; e_wdata <= '0;
               streak <= 0;
            end else begin
               streak <= 0;
            end
         end else begin
            if (!bus.IF_Req_IN) streak <= 0;
            age <= age + 1;
            if (bus.Mem_Ack_IN || age + 1 == TIMEOUT) begin
               owner <= OWN_NONE; e_req <= 1'b0;
               if (!bus.Mem_Ack_IN) e_error <= 1'b1;
               if (owner == OWN_IF) begin
                  e_if_valid <= 1'b1;
                  e_if_data  <= bus.Mem_Ack_IN ? bus.Mem_RData_IN : '0;
               end else begin
                  e_mem_valid <= 1'b1;
                  if (!bus.Mem_Ack_IN) e_mem_rdata <= '0;
                  else if (!e_write)   e_mem_rdata <= bus.Mem_RData_IN;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model.
   always @(negedge CLK) begin
      check("IF_Grant",  32'(bus.IF_Grant_OUT),  32'(e_if_grant));
      check("IF_Valid",  32'(bus.IF_Valid_OUT),  32'(e_if_valid));
      check("IF_Data",   32'(bus.IF_Data_OUT),   32'(e_if_data));
      check("MEM_Grant", 32'(bus.MEM_Grant_OUT), 32'(e_mem_grant));
      check("MEM_Valid", 32'(bus.MEM_Valid_OUT), 32'(e_mem_valid));
      check("MEM_RData", 32'(bus.MEM_RData_OUT), 32'(e_mem_rdata));
      check("Mem_Req",   32'(bus.Mem_Req_OUT),   32'(e_req));
      check("Error",     32'(bus.Error_OUT),     32'(e_error));
      if (e_req) begin
         check("Mem_Write", 32'(bus.Mem_Write_OUT), 32'(e_write));
         check("Mem_Addr",  32'(bus.Mem_Addr_OUT),  32'(e_addr));
         check("Mem_WData", 32'(bus.Mem_WData_OUT), 32'(e_wdata));
      end
   end

   function automatic logic pick(input int which);
      case (which)
         W_IF_GRANT:  return bus.IF_Grant_OUT;
         W_IF_VALID:  return bus.IF_Valid_OUT;
         W_MEM_GRANT: return bus.MEM_Grant_OUT;
         default:     return bus.MEM_Valid_OUT;
      endcase
   endfunction

   // Wait up to budget cycles for an output pulse; at = cycle seen, or -1 on expiry.
   task automatic wait_out(input int which, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (pick(which) === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      int k, at, seq, n, busy;
      RESET = 1'b1;
      bus.IF_Req_IN = 1'b0;  bus.IF_Addr_IN = '0;
      bus.MEM_Req_IN = 1'b0; bus.MEM_Write_IN = 1'b0; bus.MEM_Addr_IN = '0; bus.MEM_WData_IN = '0;
      repeat (3) @(negedge CLK);
      check("reset Mem_Req", 32'(bus.Mem_Req_OUT), 32'h0);
      check("reset Error",   32'(bus.Error_OUT),   32'h0);
      check("reset IF_Data", 32'(bus.IF_Data_OUT), 32'h0);
      RESET = 1'b0;

      // Acknowledges while idle must be ignored.
      stray = 1'b1;
      repeat (3) @(negedge CLK);
      stray = 1'b0;
      check("stray ack IF_Valid",  32'(bus.IF_Valid_OUT),  32'h0);
      check("stray ack MEM_Valid", 32'(bus.MEM_Valid_OUT), 32'h0);

      // Zero-wait fetch of 0x004.
      @(negedge CLK);
      bus.IF_Addr_IN = 10'h004; bus.IF_Req_IN = 1'b1; k = cyc;
      wait_out(W_IF_GRANT, 5, at); check("fetch grant cycle", at, k + 1);
      check("fetch Mem_Addr", 32'(bus.Mem_Addr_OUT), 32'h004);
      wait_out(W_IF_VALID, 5, at); check("fetch valid cycle", at, k + 2);
      check("fetch data", 32'(bus.IF_Data_OUT), 32'hABCDE);
      bus.IF_Req_IN = 1'b0;

      // Simultaneous requests: MEM load 0x010 first, IF right after MEM_Valid.
      @(negedge CLK);
      bus.IF_Addr_IN = 10'h008; bus.IF_Req_IN = 1'b1;
      bus.MEM_Addr_IN = 10'h010; bus.MEM_Write_IN = 1'b0; bus.MEM_Req_IN = 1'b1; k = cyc;
      wait_out(W_MEM_GRANT, 5, at); check("tie MEM grant cycle", at, k + 1);
      check("tie IF not first", 32'(bus.IF_Grant_OUT), 32'h0);
      wait_out(W_MEM_VALID, 5, at); check("tie MEM valid cycle", at, k + 2);
      bus.MEM_Req_IN = 1'b0;
      check("tie MEM data", 32'(bus.MEM_RData_OUT), 32'hED410);
      wait_out(W_IF_GRANT, 5, at); check("tie IF grant cycle", at, k + 3);
      wait_out(W_IF_VALID, 5, at); check("tie IF valid cycle", at, k + 4);
      bus.IF_Req_IN = 1'b0;
      check("tie IF data", 32'(bus.IF_Data_OUT), 32'hEB408);

      // Starvation limit: MEM held continuously with IF waiting -> MEM, MEM, MEM, IF.
      @(negedge CLK);
      bus.IF_Addr_IN = 10'h008; bus.IF_Req_IN = 1'b1;
      bus.MEM_Addr_IN = 10'h030; bus.MEM_Write_IN = 1'b0; bus.MEM_Req_IN = 1'b1;
      seq = 0; n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge CLK);
         if (bus.MEM_Grant_OUT === 1'b1) begin seq = seq << 1;        n++; end
         if (bus.IF_Grant_OUT  === 1'b1) begin seq = (seq << 1) | 1;  n++; end
      end
      check("starve grant count", n, 4);
      check("starve grant order", seq, 32'b0001);
      wait_out(W_IF_VALID, 5, at); check("starve IF valid seen", 32'(at >= 0), 32'h1);
      bus.IF_Req_IN = 1'b0;
      wait_out(W_MEM_GRANT, 5, at);
      wait_out(W_MEM_VALID, 5, at); check("starve last MEM valid seen", 32'(at >= 0), 32'h1);
      bus.MEM_Req_IN = 1'b0;
      check("starve MEM data", 32'(bus.MEM_RData_OUT), 32'hE5430);

      // Store 0x00155 to 0x020, acknowledged in its 4th cycle.
      @(negedge CLK);
      ack_delay = 3;
      bus.MEM_Addr_IN = 10'h020; bus.MEM_Write_IN = 1'b1; bus.MEM_WData_IN = 20'h00155;
      bus.MEM_Req_IN = 1'b1;
      busy = 0; at = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.Mem_Req_OUT === 1'b1) begin
            busy++;
            check("store Mem_Write", 32'(bus.Mem_Write_OUT), 32'h1);
            check("store Mem_Addr",  32'(bus.Mem_Addr_OUT),  32'h020);
            check("store Mem_WData", 32'(bus.Mem_WData_OUT), 32'h00155);
         end
         if (bus.MEM_Valid_OUT === 1'b1) begin at = cyc; break; end
      end
      bus.MEM_Req_IN = 1'b0; bus.MEM_Write_IN = 1'b0; bus.MEM_WData_IN = '0;
      ack_delay = 0;
      check("store valid seen", 32'(at >= 0), 32'h1);
      check("store busy cycles", busy, 4);
      check("store keeps MEM_RData", 32'(bus.MEM_RData_OUT), 32'hE5430);

      // Fetch with no acknowledge: times out after TIMEOUT busy cycles.
      @(negedge CLK);
      ack_delay = -1;
      bus.IF_Addr_IN = 10'h040; bus.IF_Req_IN = 1'b1; k = cyc;
      wait_out(W_IF_GRANT, 5, at);  check("timeout grant cycle", at, k + 1);
      wait_out(W_IF_VALID, 30, at); check("timeout valid cycle", at, k + 1 + TIMEOUT);
      bus.IF_Req_IN = 1'b0;
      check("timeout data zero", 32'(bus.IF_Data_OUT), 32'h0);
      check("timeout Error set", 32'(bus.Error_OUT), 32'h1);
      ack_delay = 0;
      @(negedge CLK);
      bus.MEM_Addr_IN = 10'h010; bus.MEM_Req_IN = 1'b1;
      wait_out(W_MEM_VALID, 5, at);
      bus.MEM_Req_IN = 1'b0;
      check("Error sticky", 32'(bus.Error_OUT), 32'h1);
      check("post-timeout load data", 32'(bus.MEM_RData_OUT), 32'hED410);

      // Reset two cycles into a pending fetch.
      @(negedge CLK);
      ack_delay = -1;
      bus.IF_Addr_IN = 10'h050; bus.IF_Req_IN = 1'b1;
      wait_out(W_IF_GRANT, 5, at); check("abort grant seen", 32'(at >= 0), 32'h1);
      repeat (2) @(negedge CLK);
      #2;
      RESET = 1'b1; bus.IF_Req_IN = 1'b0;
      #1;
      check("reset drops Mem_Req", 32'(bus.Mem_Req_OUT), 32'h0);
      check("reset clears Error",  32'(bus.Error_OUT),   32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("no IF_Valid in reset", 32'(bus.IF_Valid_OUT), 32'h0);
         check("no grant in reset",    32'(bus.IF_Grant_OUT | bus.MEM_Grant_OUT), 32'h0);
      end
      ack_delay = 0;
      RESET = 1'b0;
      @(negedge CLK);
      bus.IF_Addr_IN = 10'h004; bus.IF_Req_IN = 1'b1; k = cyc;
      wait_out(W_IF_GRANT, 5, at); check("after reset grant cycle", at, k + 1);
      wait_out(W_IF_VALID, 5, at); check("after reset valid cycle", at, k + 2);
      bus.IF_Req_IN = 1'b0;
      check("after reset data", 32'(bus.IF_Data_OUT), 32'hABCDE);
      check("after reset Error", 32'(bus.Error_OUT), 32'h0);

      repeat (3) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
